// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types, defaults and helpers for the skid pipeline stage
package pipe_pkg;

    typedef enum logic [1:0] {
        PIPE_EMPTY = 2'b00,
        PIPE_ONE   = 2'b01,
        PIPE_FULL  = 2'b11
    } pipe_state_e;

    localparam int PIPE_DEF_DATA_W = 64;
    localparam int PIPE_DEF_CNT_W  = 32;

    // EX/MEM payload; the stage treats it as an opaque bit vector
    typedef struct packed {
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [1:0]  mem_size;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } exmem_payload_t;

    // MEM/WB payload
    typedef struct packed {
        logic [31:0] wb_data;
        logic [4:0]  rd;
        logic        reg_write;
    } memwb_payload_t;

    // Entries held for a {skid_v, main_v} state; the unreachable 10 maps to 0
    function automatic logic [1:0] pipe_occupancy(input logic [1:0] st);
        case (st)
            PIPE_ONE:  return 2'd1;
            PIPE_FULL: return 2'd2;
            default:   return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready/data handshake bundle with master/slave modports
interface pipe_stage_skid_if
    import pipe_pkg::*;
#(
    parameter int DATA_W = PIPE_DEF_DATA_W
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating up-counter with synchronous clear
module pipe_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count qualifying cycles, sticking at all-ones
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline register with 2-entry skid buffer; PIPE_PERF_CNT_EN adds stall/bubble counters
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = PIPE_DEF_DATA_W,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = PIPE_DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_skid_if.slave   up,
    pipe_stage_skid_if.master  dn,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    localparam logic [1:0] ST_EMPTY = PIPE_EMPTY;
    localparam logic [1:0] ST_ONE   = PIPE_ONE;
    localparam logic [1:0] ST_FULL  = PIPE_FULL;

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic [1:0]        state;
    logic              in_fire;
    logic              out_fire;

    // in_ready comes straight from the skid flag, so no combinational path from out_ready
    assign up.ready  = !skid_v;
    assign dn.valid  = main_v;
    assign dn.data   = main_d;
    assign state     = {skid_v, main_v};
    assign occupancy = pipe_occupancy(state);
    assign in_fire   = up.valid && !skid_v;
    assign out_fire  = main_v && dn.ready;

    // Main/skid entry update: reset beats flush beats normal flow
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= RESET_VAL;
            skid_d <= RESET_VAL;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_v <= 1'b1;
                        main_d <= up.data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d <= up.data;
                    end else if (out_fire) begin
                        main_v <= 1'b0;
                    end else if (in_fire) begin
                        skid_v <= 1'b1;
                        skid_d <= up.data;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d <= skid_d;
                        skid_v <= 1'b0;
                    end
                end
                default: begin
                    // Skid without main cannot arise; fall back to empty if it ever does
                    main_v <= 1'b0;
                    skid_v <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stall_cond;
    logic bubble_cond;

    assign stall_cond  = main_v && !dn.ready;
    assign bubble_cond = dn.ready && !main_v;

    pipe_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall_cond),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (bubble_cond),
        .count (bubble_cnt)
    );
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - scoreboard bench for pipe_stage_skid against a depth-2 FIFO model
module tb_pipe_stage_skid;

    localparam int          DATA_W = 32;
    localparam int          CNT_W  = 3;
    localparam logic [31:0] RST_V  = 32'h2;
    localparam int          SAT    = (1 << CNT_W) - 1;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic [1:0]       occupancy;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_stage_skid_if #(.DATA_W(DATA_W)) up_if ();
    pipe_stage_skid_if #(.DATA_W(DATA_W)) dn_if ();

    pipe_stage_skid #(
        .DATA_W    (DATA_W),
        .RESET_VAL (RST_V),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .up         (up_if),
        .dn         (dn_if),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          fresh = 1'b1;
    bit          mon_en = 1'b0;
    int          exp_stall = 0;
    int          exp_bubble = 0;
    int          beats = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the accepted beat (if any) enters the scoreboard after the edge
    task automatic cyc(input bit iv, input logic [31:0] d, input bit ordy, input bit fl, input bit rs,
                       output bit accepted);
        bit will_fire;
        @(negedge clk);
        #1;
        up_if.valid = iv;
        up_if.data  = d;
        dn_if.ready = ordy;
        flush       = fl;
        reset       = rs;
        will_fire   = iv && (exp_q.size() < 2);
        @(posedge clk);
        #1;
        accepted = 1'b0;
        if (rs || fl) begin
            exp_q.delete();
            fresh = 1'b1;
        end else if (will_fire) begin
            exp_q.push_back(d);
            fresh    = 1'b0;
            accepted = 1'b1;
        end
    endtask

    // Monitor: compares DUT outputs to the model between edges and retires delivered beats
    initial begin
        int          sz;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                sz = exp_q.size();
                check("out_valid", 64'(dn_if.valid), 64'(sz > 0));
                check("in_ready", 64'(up_if.ready), 64'(sz < 2));
                check("occupancy", 64'(occupancy), 64'(sz));
                check("stall_cnt", 64'(stall_cnt), PERF ? 64'(exp_stall) : 64'd0);
                check("bubble_cnt", 64'(bubble_cnt), PERF ? 64'(exp_bubble) : 64'd0);
                if (sz == 0 && fresh) check("out_data_reset_val", 64'(dn_if.data), 64'(RST_V));
                if (dn_if.valid && dn_if.ready) begin
                    if (sz == 0) begin
                        check("pop_on_empty_model", 64'(dn_if.valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        beats++;
                        check("out_data", 64'(dn_if.data), 64'(e));
                    end
                end
                if (reset) begin
                    exp_stall  = 0;
                    exp_bubble = 0;
                end else begin
                    if (sz > 0 && !dn_if.ready && exp_stall < SAT) exp_stall++;
                    if (sz == 0 && dn_if.ready && exp_bubble < SAT) exp_bubble++;
                end
            end
        end
    end

    initial begin
        bit acc;
        up_if.valid = 1'b0;
        up_if.data  = '0;
        dn_if.ready = 1'b0;
        flush       = 1'b0;
        reset       = 1'b1;

        cyc(0, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 1, acc);
        mon_en = 1'b1;

        // idle with out_ready high: bubbles, RESET_VAL visible
        cyc(0, 0, 1, 0, 0, acc);
        cyc(0, 0, 1, 0, 0, acc);

        // streaming 0x1..0x10
        for (int i = 1; i <= 16; i++) cyc(1, 32'(i), 1, 0, 0, acc);
        cyc(0, 0, 1, 0, 0, acc);
        cyc(0, 0, 1, 0, 0, acc);

        // backpressure: A, B captured while stalled, C held off then accepted
        cyc(1, 32'hA, 0, 0, 0, acc);
        cyc(1, 32'hB, 0, 0, 0, acc);
        for (int i = 0; i < 3; i++) cyc(1, 32'hC, 0, 0, 0, acc);
        check("bp_occupancy_full", 64'(occupancy), 64'd2);
        check("bp_holds_A", 64'(dn_if.data), 64'hA);
        acc = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) cyc(1, 32'hC, 1, 0, 0, acc);
        check("bp_C_accepted", 64'(acc), 64'd1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, acc);

        // flush while FULL with 0xD presented
        cyc(1, 32'h11, 0, 0, 0, acc);
        cyc(1, 32'h12, 0, 0, 0, acc);
        cyc(1, 32'hD, 0, 1, 0, acc);
        check("flush_in_ready", 64'(up_if.ready), 64'd1);
        check("flush_out_data", 64'(dn_if.data), 64'(RST_V));
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, acc);

        // long stall for counter saturation, then reset mid-stream
        cyc(1, 32'h21, 0, 0, 0, acc);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, acc);
        cyc(1, 32'h22, 1, 0, 0, acc);
        cyc(1, 32'h23, 0, 0, 1, acc);
        check("reset_out_valid", 64'(dn_if.valid), 64'd0);
        check("reset_out_data", 64'(dn_if.data), 64'(RST_V));
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0, acc);

        // random valid/ready toggling with occasional flush and reset
        for (int i = 0; i < 24000; i++) begin
            bit iv, ordy, fl, rs;
            int mode;
            mode = (i / 500) % 3;
            iv   = (mode == 1) ? 1'b1 : ($urandom_range(3) != 0);
            ordy = (mode == 2) ? ($urandom_range(3) == 0) : ($urandom_range(2) != 0);
            fl   = ($urandom_range(96) == 0);
            rs   = ($urandom_range(2999) == 0);
            cyc(iv, $urandom, ordy, fl, rs, acc);
        end

        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, acc);
        check("drained_out_valid", 64'(dn_if.valid), 64'd0);
        @(negedge clk);
        #3;
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Generic parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer, replacing the hand-written per-stage registers (EX/MEM, MEM/WB) with one reusable block. The payload is an opaque DATA_W-bit bundle packed by the instantiating stage. Stalls are handled with backpressure instead of a global hold, so a stall no longer needs a combinational ready path across stages. It supports a synchronous flush, a per-bit reset value and optional saturating stall/bubble counters.

## Interface
- DATA_W, 64: payload width in bits (≥1).
- RESET_VAL, '0: DATA_W-bit payload value driven after reset/flush (e.g. mem_size field = 2'b10).
- CNT_W, 32: perf counter width (≥2); used only with PIPE_PERF_CNT_EN.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous kill of both entries.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  downstream payload valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  payload from main entry.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready.
- bubble_cnt  out  CNT_W  cycles with out_ready && !out_valid.

## Operation
- Storage: main entry (main_v, main_d) and skid entry (skid_v, skid_d). out_valid = main_v, out_data = main_d, in_ready = !skid_v.
- in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- States, encoded as {skid_v, main_v}: EMPTY (00), ONE (01), FULL (11). 10 is illegal and never reached.
- EMPTY: on in_fire, main <= in_data → ONE; otherwise stay.
- ONE:
  - in_fire && out_fire: main <= in_data, stay ONE.
  - out_fire only → EMPTY.
  - in_fire only: skid <= in_data → FULL.
  - neither: hold.
- FULL: in_ready = 0. On out_fire, main <= skid_d and skid_v <= 0 → ONE; otherwise hold.
- Priority: reset > flush > normal.
- Reset and flush:
  - main_v = skid_v = 0.
  - main_d = skid_d = RESET_VAL.
  - in_ready = 1 in the next cycle.
  - A transfer presented in the flush cycle is discarded on both sides. Downstream treats out_fire in the flush cycle as a real transfer; the stage only drops its own copy.
- While out_valid && !out_ready, out_data is stable. Ordering is strict FIFO; no payload is ever dropped or duplicated.
- occupancy: 0 / 1 / 2 for EMPTY / ONE / FULL.
- Reset values of outputs: out_valid 0, out_data RESET_VAL, in_ready 1, occupancy 0, stall_cnt 0, bubble_cnt 0.

## Timing
- Latency: in_fire at cycle N → out_valid with that payload at cycle N+1.
- Throughput: 1 transfer/cycle sustained when out_ready stays high.
- in_ready depends only on registers; there is no in_valid/out_ready → in_ready combinational path.
- When out_ready drops, at most one extra beat is absorbed (into skid). in_ready falls the cycle after skid fills and rises the cycle after skid drains.
- Flush and out_ready low in the same cycle: flush wins; the stage is EMPTY next cycle.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cnt and bubble_cnt increment once per qualifying cycle.
  - Both saturate at all-ones.
  - Both are cleared by reset only; flush does not clear them.
- Undefined: no counter logic; stall_cnt and bubble_cnt are tied to 0. The port list is unchanged.

## Structure
- Package pipe_pkg:
  - typedef pipe_state_e {PIPE_EMPTY=2'b00, PIPE_ONE=2'b01, PIPE_FULL=2'b11}.
  - Constants PIPE_DEF_DATA_W=64 and PIPE_DEF_CNT_W=32.
  - Stage payload struct typedefs (exmem_payload_t, memwb_payload_t) so stages pack and unpack consistently.
- Sub-module pipe_sat_counter (WIDTH, inc, clear, count) is instantiated twice under PIPE_PERF_CNT_EN.

## Test plan
- Streaming: DATA_W=32, out_ready=1, in_data 0x1..0x10 on consecutive cycles → out_data 0x1..0x10 one cycle later, in_ready constantly 1, occupancy 1.
- Backpressure: send 0xA, 0xB, then drop out_ready for 3 cycles while in_valid=1 with 0xC →
  - occupancy reaches 2 and in_ready = 0.
  - out_data holds 0xA.
  - After out_ready returns: output order 0xA, 0xB, 0xC with no loss or duplication.
- Flush in FULL: flush with occupancy=2 and in_valid=1 (0xD) → next cycle out_valid=0, out_data=RESET_VAL, in_ready=1; 0xD is never output.
- Reset mid-stream with RESET_VAL=0x2 → out_data=0x2, out_valid=0, in_ready=1 after one clock.
- Counters (PIPE_PERF_CNT_EN, CNT_W=2):
  - 5 cycles of out_valid=1, out_ready=0 → stall_cnt=3 (saturated).
  - 2 idle cycles with out_ready=1 → bubble_cnt=2.
  - A flush leaves both counters unchanged.
- Random valid/ready toggling over 10k beats against a scoreboard FIFO → zero mismatches and state 10 never observed.
